// File: rtl/uriscv_ahb_pkg.sv
// uriscv_ahb_pkg
//   Shared definitions for the uriscv AHB-Lite master bridge:
//   - the htrans encoding;
//   - the hsize and hburst constants;
//   - the control part of a pipeline slot (AP/DP).
//   The data-width-dependent slot fields (address, write data, tag) are held
//   next to the struct in the top, because a package cannot see the
//   module's width parameters.
package uriscv_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Width-independent state of one pipeline slot.
  //   vld  : slot holds a live request
  //   lerr : request was rejected locally and never goes on the bus
  typedef struct packed {
    logic vld;
    logic lerr;
  } slot_ctl_t;

endpackage

// File: rtl/uriscv_ahb_strb_decode.sv
// uriscv_ahb_strb_decode
//   Purely combinational decode of a core byte-strobe into an AHB transfer
//   size and the low address bits.
//   Ports:
//     i_strb  : write byte strobes (nonzero = write)
//     i_rd    : read request flag (only consulted when i_strb is zero)
//     o_size  : hsize value
//     o_lo    : low haddr bits (byte offset within the data bus)
//     o_legal : request may go on the bus
//   A read always covers the full bus width at offset 0.
//   A write is legal only when the strobe is a single aligned block of
//   1, 2, 4 (or 8) bytes.
module uriscv_ahb_strb_decode #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W/8-1:0]         i_strb,
  input  logic                        i_rd,
  output logic [2:0]                  o_size,
  output logic [$clog2(DATA_W/8)-1:0] o_lo,
  output logic                        o_legal
);

  localparam int NB   = DATA_W / 8;
  localparam int LO_W = $clog2(NB);

  always_comb begin
    o_size  = 3'(LO_W);
    o_lo    = '0;
    o_legal = i_rd;
    if (|i_strb) begin
      o_legal = 1'b0;
      // Match the strobe against every aligned block of 2^s bytes.
      for (int s = 0; s <= LO_W; s++) begin
        for (int k = 0; k < NB; k++) begin
          if ((k % (1 << s)) == 0 &&
              i_strb == NB'(((1 << (1 << s)) - 1) << k)) begin
            o_legal = 1'b1;
            o_size  = 3'(s);
            o_lo    = LO_W'(k);
          end
        end
      end
    end
  end

endmodule

// File: rtl/uriscv_ahb_master.sv
// uriscv_ahb_master
//   AHB-Lite master bridge for the uriscv core memory-out port.
//   It uses a two-slot pipeline:
//   - AP holds the request currently driving the address phase;
//   - DP holds the request whose data phase is in progress.
//   Up to two transfers are in flight, and completions return in request
//   order.
//   Ports:
//     hclk / hreset_n         : clock, async active-low reset
//     req_rd_i / req_wr_i     : read flag / write byte strobes
//     req_addr_i / req_data_i : byte address / lane-positioned write data
//     req_tag_i               : tag, echoed on completion
//     req_accept_o            : request taken this cycle
//     resp_ack_o              : one-cycle completion pulse
//     resp_data_o             : read data
//     resp_tag_o              : tag of the completing request
//     resp_error_o            : completion with error
//     htrans..hprot           : AHB-Lite master outputs
//     hrdata / hready / hresp : AHB-Lite slave responses
module uriscv_ahb_master
  import uriscv_ahb_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         TAG_W     = 11,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                hclk,
  input  logic                hreset_n,
  input  logic                req_rd_i,
  input  logic [DATA_W/8-1:0] req_wr_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  output logic                req_accept_o,
  output logic                resp_ack_o,
  output logic [DATA_W-1:0]   resp_data_o,
  output logic [TAG_W-1:0]    resp_tag_o,
  output logic                resp_error_o,
  output logic [1:0]          htrans,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic                hwrite,
  output logic [ADDR_W-1:0]   haddr,
  output logic [DATA_W-1:0]   hwdata,
  output logic [3:0]          hprot,
  input  logic [DATA_W-1:0]   hrdata,
  input  logic                hready,
  input  logic                hresp
);

  localparam int NB   = DATA_W / 8;
  localparam int LO_W = $clog2(NB);

  // AP slot
  slot_ctl_t         r_ap;
  logic [ADDR_W-1:0] r_ap_addr;
  logic [2:0]        r_ap_size;
  logic              r_ap_wr;
  logic [DATA_W-1:0] r_ap_wdata;
  logic [TAG_W-1:0]  r_ap_tag;

  // DP slot
  slot_ctl_t         r_dp;
  logic [DATA_W-1:0] r_dp_wdata;
  logic [TAG_W-1:0]  r_dp_tag;

  logic              w_req_vld;
  logic              w_is_wr;
  logic              w_err1;
  logic              w_accept;
  logic [2:0]        w_size;
  logic [LO_W-1:0]   w_lo;
  logic              w_legal;
  logic              w_unused_addr_lo;

  assign w_is_wr   = |req_wr_i;
  assign w_req_vld = req_rd_i | w_is_wr;

  // The low address bits come from the strobe decode, not from the core.
  assign w_unused_addr_lo = ^req_addr_i[LO_W-1:0];

  uriscv_ahb_strb_decode #(.DATA_W(DATA_W)) u_decode (
    .i_strb  (req_wr_i),
    .i_rd    (req_rd_i),
    .o_size  (w_size),
    .o_lo    (w_lo),
    .o_legal (w_legal)
  );

  // First cycle of a two-cycle ERROR response. The pending address phase
  // is withdrawn (IDLE) and AP holds, so it is re-driven afterwards.
  assign w_err1   = r_dp.vld & hresp & ~hready;
  assign w_accept = ~r_ap.vld | (hready & ~w_err1);

  // AP: loads on every accept. With no request it simply goes invalid.
  // Its payload is left untouched in that case, so the bus outputs do
  // not toggle needlessly.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_ap       <= '0;
      r_ap_addr  <= '0;
      r_ap_size  <= HSIZE_WORD;
      r_ap_wr    <= 1'b0;
      r_ap_wdata <= '0;
      r_ap_tag   <= '0;
    end else if (w_accept) begin
      r_ap.vld <= w_req_vld;
      if (w_req_vld) begin
        r_ap.lerr  <= ~w_legal;
        r_ap_addr  <= {req_addr_i[ADDR_W-1:LO_W], w_lo};
        r_ap_size  <= w_size;
        r_ap_wr    <= w_is_wr;
        r_ap_wdata <= req_data_i;
        r_ap_tag   <= req_tag_i;
      end
    end
  end

  // DP: follows AP whenever the bus advances. Locally-rejected entries
  // ride along too, which keeps completion order equal to request order.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_dp       <= '0;
      r_dp_wdata <= '0;
      r_dp_tag   <= '0;
    end else if (hready) begin
      r_dp       <= r_ap;
      r_dp_wdata <= r_ap_wdata;
      r_dp_tag   <= r_ap_tag;
    end
  end

  assign htrans = (r_ap.vld & ~r_ap.lerr & ~w_err1) ? NONSEQ : IDLE;
  assign haddr  = r_ap_addr;
  assign hsize  = r_ap_size;
  assign hwrite = r_ap_wr;
  assign hwdata = r_dp_wdata;
  assign hburst = HBURST_SINGLE;
  assign hprot  = HPROT_VAL;

  assign req_accept_o = w_accept;
  assign resp_ack_o   = r_dp.vld & hready;
  assign resp_data_o  = hrdata;
  assign resp_tag_o   = r_dp_tag;
  assign resp_error_o = r_dp.lerr | hresp;

endmodule
